dram_pattern_tester: RTL
========================

# dram_pattern_tester

Parametrised self-running memory tester for the DRAM test build. It drives a `dram_control`-style controller through its start/rnw/stop/ready handshake and loops write-pass / read-compare-pass over the whole array. It offers three data patterns plus an auto-cycling mode, and keeps saturating pass/fail counters. Optional capture of the first failing word supports bench debugging.

## Interface
- `DATA_SIZE`, 16: data word width.
- `ADDR_SIZE`, 20: width of the internal word-index counter; it wraps modulo 2^ADDR_SIZE.
- `LFSR_LENGTH`, 17: random generator length. Must be ≥ `DATA_SIZE`.
- `LFSR_FEEDBACK`, 14: tap index XORed with the top bit.
- `CNT_SIZE`, 16: width of the pass and fail counters.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: enables looping. Sampled only in IDLE and PASS_END.
- `mode` in 2: 0 = LFSR, 1 = address, 2 = inverted address, 3 = cycle 0→1→2 per pass.
- `ram_start` out 1: one-cycle pulse that begins a controller pass.
- `ram_rnw` out 1: 1 = read, 0 = write. Held stable for the whole pass.
- `ram_stop` in 1: high while the controller is idle or finished.
- `ram_ready` in 1: one pulse per word transferred.
- `ram_rdat` in DATA_SIZE: read data, valid in the cycle `ram_ready` is high.
- `ram_wdat` out DATA_SIZE: write data for the current word index.
- `pass_counter` out CNT_SIZE: error-free passes, saturating.
- `fail_counter` out CNT_SIZE: passes with at least one mismatch, saturating.
- `cur_pattern` out 2: pattern (0–2) in use for the current pass.
- `busy` out 1: high in every state except IDLE.
- `err_valid` out 1: sticky; set by the first mismatch since reset.
- `err_addr` out ADDR_SIZE: word index of the first mismatch.
- `err_exp` out DATA_SIZE: expected data of the first mismatch.
- `err_got` out DATA_SIZE: read data of the first mismatch.

## Operation
States and transitions:
- IDLE → INIT when `run` is high.
- INIT: pulses `ram_start` with `ram_rnw`=1, then waits for `ram_stop`. This is a dummy read, not compared.
- W_SETUP: latches the pattern (`mode`, or the cycling sequence if `mode`=3) and saves the LFSR state.
- W_START: pulses `ram_start` with `ram_rnw`=0.
- W_WAIT: waits for `ram_stop` to go low.
- WRITE: runs until `ram_stop` goes high.
- R_SETUP: restores the LFSR state.
- R_START, R_WAIT, READ: same as the write sequence, with `ram_rnw`=1.
- FLUSH: one cycle that lets the last registered compare land.
- PASS_END: updates the counters, then goes to W_SETUP if `run` is high, else to IDLE.

Word index:
- Cleared in W_SETUP and R_SETUP.
- Increments on each `ram_ready` during WRITE and READ.

Data patterns (`ram_wdat`, and the expected data on read):
- Pattern 0: low `DATA_SIZE` bits of the LFSR. The LFSR steps on each `ram_ready` during WRITE and READ. It is never reseeded after reset, so every pass uses fresh data.
- Pattern 1: word index, zero-extended or truncated to `DATA_SIZE`.
- Pattern 2: bitwise inverse of pattern 1.

Compare and counters:
- In READ, when `ram_ready` is high and `ram_rdat` ≠ expected, a mismatch is registered one cycle later.
- A registered mismatch sets the per-pass `was_error` flag.
- PASS_END increments `fail_counter` if `was_error` is set, else `pass_counter`. Either counter holds at all-ones. `was_error` is then cleared.
- Pattern cycling (`mode`=3) advances 0→1→2→0 at each PASS_END.
- Dropping `run` mid-pass finishes the current pass; it is never aborted.

## Timing
- Reset values: `ram_start`=0, `ram_rnw`=1, `ram_wdat`=0, counters=0, `cur_pattern`=0, `busy`=0, `err_*`=0, state IDLE.
- LFSR reset seed is all-ones except bit 0, which is 0. The seed must never be all-zero.
- `ram_start` is high for exactly one cycle per pass.
- `ram_rnw` changes only in SETUP states, never while the controller is busy.
- `ram_wdat` is valid from W_START and updates the cycle after each `ram_ready`.
- `ram_ready` and the `ram_stop` rise in the same cycle: the word is still counted and compared.
- A mismatch on the last word is counted, because FLUSH precedes PASS_END.
- Latency from the final `ram_stop` of READ to the counter update is 2 cycles.
- Asserting `rst_n` mid-pass forces reset values immediately. The controller sees `ram_start`=0.

## Configuration
- `MEM_TESTER_ERR_CAPTURE_EN`
  - Defined: the `err_valid`, `err_addr`, `err_exp` and `err_got` registers are built. They load on the first registered mismatch and then stay frozen until reset.
  - Undefined: those outputs are tied to 0, and counting is unchanged.

## Test plan
- Behavioural 1K-word memory with no faults, `mode`=0, `run`=1, 5 passes → `pass_counter`=5, `fail_counter`=0, `err_valid`=0.
- Memory bit 3 stuck-at-1 at word 0x155, `mode`=1 → `fail_counter` increments every pass, `err_addr`=0x155, `err_exp`=0x0155, `err_got`=0x015D.
- `mode`=3 over 6 passes → `cur_pattern` sequence 0,1,2,0,1,2; the write data of pattern 2 at word 0x002 is 0xFFFD.
- Fault on the last word (0x3FF), `ram_ready` coincident with the `ram_stop` rise → `fail_counter`=1 after that pass.
- `CNT_SIZE`=2, fault-free, 5 passes → `pass_counter` stays at 3; `run` dropped mid-READ → the pass completes, then `busy`=0.
- `rst_n` pulsed low mid-WRITE → all outputs at reset values in the same cycle; after release with `run`=1 the tester restarts from INIT.

Source files
------------

// File: rtl/dram_pattern_tester.sv
// Self-running write-pass / read-compare-pass memory tester for a dram_control-style controller.
// Define MEM_TESTER_ERR_CAPTURE_EN to build the first-mismatch capture registers (err_*).
module dram_pattern_tester #(
    parameter int unsigned DATA_SIZE     = 16,
    parameter int unsigned ADDR_SIZE     = 20,
    parameter int unsigned LFSR_LENGTH   = 17,
    parameter int unsigned LFSR_FEEDBACK = 14,
    parameter int unsigned CNT_SIZE      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [1:0]           mode,
    output logic                 ram_start,
    output logic                 ram_rnw,
    input  logic                 ram_stop,
    input  logic                 ram_ready,
    input  logic [DATA_SIZE-1:0] ram_rdat,
    output logic [DATA_SIZE-1:0] ram_wdat,
    output logic [CNT_SIZE-1:0]  pass_counter,
    output logic [CNT_SIZE-1:0]  fail_counter,
    output logic [1:0]           cur_pattern,
    output logic                 busy,
    output logic                 err_valid,
    output logic [ADDR_SIZE-1:0] err_addr,
    output logic [DATA_SIZE-1:0] err_exp,
    output logic [DATA_SIZE-1:0] err_got
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT      = 4'd1;
    localparam logic [3:0] S_INIT_WAIT = 4'd2;
    localparam logic [3:0] S_INIT_RUN  = 4'd3;
    localparam logic [3:0] S_W_SETUP   = 4'd4;
    localparam logic [3:0] S_W_START   = 4'd5;
    localparam logic [3:0] S_W_WAIT    = 4'd6;
    localparam logic [3:0] S_WRITE     = 4'd7;
    localparam logic [3:0] S_R_SETUP   = 4'd8;
    localparam logic [3:0] S_R_START   = 4'd9;
    localparam logic [3:0] S_R_WAIT    = 4'd10;
    localparam logic [3:0] S_READ      = 4'd11;
    localparam logic [3:0] S_FLUSH     = 4'd12;
    localparam logic [3:0] S_PASS_END  = 4'd13;

    localparam logic [LFSR_LENGTH-1:0] LFSR_SEED = {{(LFSR_LENGTH-1){1'b1}}, 1'b0};

    logic [3:0]             state_q, state_d;
    logic [ADDR_SIZE-1:0]   idx_q, idx_d;
    logic [LFSR_LENGTH-1:0] lfsr_q, lfsr_d, lfsr_save_q, lfsr_save_d;
    logic [1:0]             pat_q, pat_d, cyc_q, cyc_d;
    logic                   was_err_q, was_err_d, mm_q, mm_d;
    logic                   start_q, start_d, rnw_q, rnw_d, busy_q, busy_d;
    logic [DATA_SIZE-1:0]   wdat_q, wdat_d, exp_c;
    logic [CNT_SIZE-1:0]    pass_q, pass_d, fail_q, fail_d;
    logic                   xfer_c;

    function automatic logic [DATA_SIZE-1:0] pattern_f(input logic [1:0] pat,
                                                       input logic [ADDR_SIZE-1:0] idx,
                                                       input logic [LFSR_LENGTH-1:0] lfsr);
        logic [DATA_SIZE-1:0] res;
        res = DATA_SIZE'(idx);
        case (pat)
            2'd0:    res = DATA_SIZE'(lfsr);
            2'd1:    res = DATA_SIZE'(idx);
            default: res = ~res;
        endcase
        return res;
    endfunction

    assign exp_c  = pattern_f(pat_q, idx_q, lfsr_q);
    assign xfer_c = ram_ready && ((state_q == S_WRITE) || (state_q == S_READ));

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        lfsr_save_d = lfsr_save_q;
        pat_d       = pat_q;
        cyc_d       = cyc_q;
        was_err_d   = was_err_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        rnw_d       = rnw_q;
        wdat_d      = wdat_q;
        mm_d        = (state_q == S_READ) && ram_ready && (ram_rdat != exp_c);
        if (mm_q) was_err_d = 1'b1;
        if (xfer_c) begin
            idx_d  = idx_q + ADDR_SIZE'(1);
            lfsr_d = {lfsr_q[LFSR_LENGTH-2:0], lfsr_q[LFSR_LENGTH-1] ^ lfsr_q[LFSR_FEEDBACK]};
        end
        case (state_q)
            S_IDLE:      if (run) state_d = S_INIT;
            S_INIT:      state_d = S_INIT_WAIT;
            S_INIT_WAIT: if (!ram_stop) state_d = S_INIT_RUN;
            S_INIT_RUN:  if (ram_stop) state_d = S_W_SETUP;
            S_W_SETUP: begin
                state_d     = S_W_START;
                idx_d       = '0;
                pat_d       = (mode == 2'd3) ? cyc_q : mode;
                lfsr_save_d = lfsr_q;
            end
            S_W_START:   state_d = S_W_WAIT;
            S_W_WAIT:    if (!ram_stop) state_d = S_WRITE;
            S_WRITE:     if (ram_stop) state_d = S_R_SETUP;
            S_R_SETUP: begin
                state_d = S_R_START;
                idx_d   = '0;
                lfsr_d  = lfsr_save_q;
            end
            S_R_START:   state_d = S_R_WAIT;
            S_R_WAIT:    if (!ram_stop) state_d = S_READ;
            S_READ:      if (ram_stop) state_d = S_FLUSH;
            S_FLUSH:     state_d = S_PASS_END;
            S_PASS_END: begin
                if (was_err_q || mm_q) begin
                    if (!(&fail_q)) fail_d = fail_q + CNT_SIZE'(1);
                end else if (!(&pass_q)) begin
                    pass_d = pass_q + CNT_SIZE'(1);
                end
                was_err_d = 1'b0;
                if (mode == 2'd3) cyc_d = (cyc_q == 2'd2) ? 2'd0 : cyc_q + 2'd1;
                state_d = run ? S_W_SETUP : S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
        // Registered controller-facing outputs follow the upcoming state
        start_d = (state_d == S_INIT) || (state_d == S_W_START) || (state_d == S_R_START);
        busy_d  = (state_d != S_IDLE);
        if (state_d == S_W_SETUP) rnw_d = 1'b0;
        if (state_d == S_R_SETUP) rnw_d = 1'b1;
        if ((state_d == S_W_START) || (state_d == S_W_WAIT) || (state_d == S_WRITE))
            wdat_d = pattern_f(pat_d, idx_d, lfsr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            lfsr_save_q <= LFSR_SEED;
            pat_q       <= 2'd0;
            cyc_q       <= 2'd0;
            was_err_q   <= 1'b0;
            mm_q        <= 1'b0;
            start_q     <= 1'b0;
            rnw_q       <= 1'b1;
            busy_q      <= 1'b0;
            wdat_q      <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            lfsr_save_q <= lfsr_save_d;
            pat_q       <= pat_d;
            cyc_q       <= cyc_d;
            was_err_q   <= was_err_d;
            mm_q        <= mm_d;
            start_q     <= start_d;
            rnw_q       <= rnw_d;
            busy_q      <= busy_d;
            wdat_q      <= wdat_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign ram_start    = start_q;
    assign ram_rnw      = rnw_q;
    assign ram_wdat     = wdat_q;
    assign pass_counter = pass_q;
    assign fail_counter = fail_q;
    assign cur_pattern  = pat_q;
    assign busy         = busy_q;

`ifdef MEM_TESTER_ERR_CAPTURE_EN
    logic [ADDR_SIZE-1:0] mm_addr_q, err_addr_q;
    logic [DATA_SIZE-1:0] mm_exp_q, mm_got_q, err_exp_q, err_got_q;
    logic                 err_valid_q;

    // Compare operands ride along with mm_q; the first registered mismatch freezes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_addr_q   <= '0;
            mm_exp_q    <= '0;
            mm_got_q    <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
        end else begin
            if ((state_q == S_READ) && ram_ready) begin
                mm_addr_q <= idx_q;
                mm_exp_q  <= exp_c;
                mm_got_q  <= ram_rdat;
            end
            if (mm_q && !err_valid_q) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= mm_addr_q;
                err_exp_q   <= mm_exp_q;
                err_got_q   <= mm_got_q;
            end
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_exp   = err_exp_q;
    assign err_got   = err_got_q;
`else
    assign err_valid = 1'b0;
    assign err_addr  = '0;
    assign err_exp   = '0;
    assign err_got   = '0;
`endif

endmodule
